// File: rtl/ga_config_ctrl.sv
// Gate Array register/configuration controller: decodes GA I/O writes and Plus
// ASIC palette writes, holds standard and Plus ink files, border colours, ROM
// enables, RAM banking, and retimes screen-mode changes to the HSYNC rise.
module ga_config_ctrl (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              SEL,
  input  logic              IOWR,
  input  logic [7:0]        D,
  input  logic              HSYNC,
  input  logic              PLUS_WR,
  input  logic [5:0]        PLUS_ADDR,
  input  logic [7:0]        PLUS_DATA,
  output logic [15:0][4:0]  INKR,
  output logic [4:0]        BORDER,
  output logic [15:0][11:0] PLUS_INKR,
  output logic [11:0]       PLUS_BORDER,
  output logic [1:0]        MODE,
  output logic              ROMEN_LO,
  output logic              ROMEN_HI,
  output logic [5:0]        RAM_CFG,
  output logic              IRQ_RESET
);

  logic              ga_wr_q, hsync_q, plus_wr_q;
  logic              ga_ev, hs_ev, plus_ev;
  logic              pen_wr, col_wr, cfg_wr, ram_wr;
  logic [4:0]        pen_sel_q;
  logic [15:0][4:0]  inkr_q;
  logic [4:0]        border_q;
  logic [15:0][11:0] plus_inkr_q;
  logic [11:0]       plus_border_q;
  logic [1:0]        mode_pend_q, mode_q, mode_d;
  logic              romen_lo_q, romen_hi_q, irq_q;
  logic [5:0]        ram_cfg_q;

  // Zeroed history makes a strobe already high at reset release count as an edge.
  assign ga_ev   = SEL & IOWR & ~ga_wr_q;
  assign hs_ev   = HSYNC & ~hsync_q;
  assign plus_ev = PLUS_WR & ~plus_wr_q;

  assign pen_wr = ga_ev & (D[7:6] == 2'b00);
  assign col_wr = ga_ev & (D[7:6] == 2'b01);
  assign cfg_wr = ga_ev & (D[7:6] == 2'b10);
  assign ram_wr = ga_ev & (D[7:6] == 2'b11);

  // Strobe and sync history for rising-edge detection
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      ga_wr_q   <= 1'b0;
      hsync_q   <= 1'b0;
      plus_wr_q <= 1'b0;
    end else begin
      ga_wr_q   <= SEL & IOWR;
      hsync_q   <= HSYNC;
      plus_wr_q <= PLUS_WR;
    end
  end

  // Pen select and standard ink/border writes
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pen_sel_q <= '0;
      inkr_q    <= '0;
      border_q  <= '0;
    end else begin
      if (pen_wr)
        pen_sel_q <= D[4] ? 5'd16 : {1'b0, D[3:0]};
      if (col_wr) begin
        if (pen_sel_q[4])
          border_q <= D[4:0];
        else
          inkr_q[pen_sel_q[3:0]] <= D[4:0];
      end
    end
  end

  // A config write landing on the HSYNC-rise cycle is forwarded straight to MODE
  always_comb begin
    mode_d = mode_q;
    if (hs_ev)
      mode_d = cfg_wr ? D[1:0] : mode_pend_q;
  end

  // Config, RAM banking, mode retime and interrupt-reset pulse
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_pend_q <= '0;
      mode_q      <= '0;
      romen_lo_q  <= 1'b1;
      romen_hi_q  <= 1'b1;
      ram_cfg_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      mode_q <= mode_d;
      irq_q  <= cfg_wr & D[4];
      if (cfg_wr) begin
        mode_pend_q <= D[1:0];
        romen_lo_q  <= ~D[2];
        romen_hi_q  <= ~D[3];
      end
      if (ram_wr)
        ram_cfg_q <= D[5:0];
    end
  end

  // Plus palette byte writes: even byte = R and B nibbles, odd byte = G nibble
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      plus_inkr_q   <= '0;
      plus_border_q <= '0;
    end else if (plus_ev) begin
      if (!PLUS_ADDR[5]) begin
        if (!PLUS_ADDR[0]) begin
          plus_inkr_q[PLUS_ADDR[4:1]][11:8] <= PLUS_DATA[7:4];
          plus_inkr_q[PLUS_ADDR[4:1]][3:0]  <= PLUS_DATA[3:0];
        end else begin
          plus_inkr_q[PLUS_ADDR[4:1]][7:4]  <= PLUS_DATA[3:0];
        end
      end else if (PLUS_ADDR[4:1] == 4'd0) begin
        if (!PLUS_ADDR[0]) begin
          plus_border_q[11:8] <= PLUS_DATA[7:4];
          plus_border_q[3:0]  <= PLUS_DATA[3:0];
        end else begin
          plus_border_q[7:4]  <= PLUS_DATA[3:0];
        end
      end
    end
  end

  assign INKR        = inkr_q;
  assign BORDER      = border_q;
  assign PLUS_INKR   = plus_inkr_q;
  assign PLUS_BORDER = plus_border_q;
  assign MODE        = mode_q;
  assign ROMEN_LO    = romen_lo_q;
  assign ROMEN_HI    = romen_hi_q;
  assign RAM_CFG     = ram_cfg_q;
  assign IRQ_RESET   = irq_q;

endmodule

// File: tb/tb_ga_config_ctrl.sv
// Directed bench for ga_config_ctrl: expected values are pushed to a scoreboard
// as stimulus is driven and popped when the DUT outputs are sampled.
module tb_ga_config_ctrl;

  logic              clk = 1'b0;
  logic              RESET_N = 1'b0;
  logic              SEL = 1'b0, IOWR = 1'b0, HSYNC = 1'b0, PLUS_WR = 1'b0;
  logic [7:0]        D = '0, PLUS_DATA = '0;
  logic [5:0]        PLUS_ADDR = '0;
  logic [15:0][4:0]  INKR;
  logic [4:0]        BORDER;
  logic [15:0][11:0] PLUS_INKR;
  logic [11:0]       PLUS_BORDER;
  logic [1:0]        MODE;
  logic              ROMEN_LO, ROMEN_HI, IRQ_RESET;
  logic [5:0]        RAM_CFG;

  ga_config_ctrl dut (
    .clk(clk), .RESET_N(RESET_N), .SEL(SEL), .IOWR(IOWR), .D(D), .HSYNC(HSYNC),
    .PLUS_WR(PLUS_WR), .PLUS_ADDR(PLUS_ADDR), .PLUS_DATA(PLUS_DATA),
    .INKR(INKR), .BORDER(BORDER), .PLUS_INKR(PLUS_INKR), .PLUS_BORDER(PLUS_BORDER),
    .MODE(MODE), .ROMEN_LO(ROMEN_LO), .ROMEN_HI(ROMEN_HI), .RAM_CFG(RAM_CFG),
    .IRQ_RESET(IRQ_RESET)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;

  string        sb_tag[$];
  logic [191:0] sb_exp[$];

  // Reference state, maintained by hand alongside each directed step
  logic [15:0][4:0]  m_inkr = '0;
  logic [4:0]        m_border = '0;
  logic [15:0][11:0] m_plus = '0;
  logic [11:0]       m_pborder = '0;
  logic [1:0]        m_mode = '0;
  logic              m_romlo = 1'b1, m_romhi = 1'b1;
  logic [5:0]        m_ram = '0;

  always @(negedge clk) if (IRQ_RESET === 1'b1) irq_cnt++;

  task automatic expect_val(input string tag, input logic [191:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic sb_check(input logic [191:0] obs);
    string        tag;
    logic [191:0] e;
    checks++;
    if (sb_exp.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h required=<entry>", obs);
    end else begin
      tag = sb_tag.pop_front();
      e   = sb_exp.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h required=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic check_all(input string step);
    expect_val({step, ".INKR"}, m_inkr);
    expect_val({step, ".BORDER"}, m_border);
    expect_val({step, ".PLUS_INKR"}, m_plus);
    expect_val({step, ".PLUS_BORDER"}, m_pborder);
    expect_val({step, ".MODE"}, m_mode);
    expect_val({step, ".ROMEN"}, {m_romlo, m_romhi});
    expect_val({step, ".RAM_CFG"}, m_ram);
    sb_check(INKR);
    sb_check(BORDER);
    sb_check(PLUS_INKR);
    sb_check(PLUS_BORDER);
    sb_check(MODE);
    sb_check({ROMEN_LO, ROMEN_HI});
    sb_check(RAM_CFG);
  endtask

  task automatic ga_write(input logic [7:0] d, input int unsigned len);
    @(negedge clk);
    SEL = 1'b1; IOWR = 1'b1; D = d;
    repeat (len) @(negedge clk);
    SEL = 1'b0; IOWR = 1'b0;
    @(negedge clk);
  endtask

  task automatic plus_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    PLUS_WR = 1'b1; PLUS_ADDR = a; PLUS_DATA = d;
    repeat (2) @(negedge clk);
    PLUS_WR = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int irq0;
    // Reset state
    repeat (2) @(negedge clk);
    expect_val("reset.IRQ_RESET", 192'd0);
    sb_check(IRQ_RESET);
    check_all("reset");
    RESET_N = 1'b1;
    @(negedge clk);

    // Pen 5 colour write
    ga_write(8'h05, 4);
    ga_write(8'h54, 4);
    m_inkr[5] = 5'h14;
    check_all("ink5");

    // Border via pen 16
    ga_write(8'h10, 4);
    ga_write(8'h4B, 4);
    m_border = 5'h0B;
    check_all("border");

    // Config write, HSYNC low: ROMs off, IRQ pulse, MODE held
    irq0 = irq_cnt;
    ga_write(8'h9E, 4);
    m_romlo = 1'b0; m_romhi = 1'b0;
    check_all("cfg9E");
    expect_val("cfg9E.irq_pulses", 192'd1);
    sb_check(irq_cnt - irq0);

    // HSYNC rise applies pending mode
    @(negedge clk); HSYNC = 1'b1;
    @(negedge clk);
    m_mode = 2'd2;
    expect_val("hsync_rise.MODE", m_mode);
    sb_check(MODE);
    HSYNC = 1'b0;
    repeat (2) @(negedge clk);

    // Config write coincident with HSYNC rise is forwarded
    irq0 = irq_cnt;
    SEL = 1'b1; IOWR = 1'b1; D = 8'h81; HSYNC = 1'b1;
    @(negedge clk);
    m_mode = 2'd1; m_romlo = 1'b1; m_romhi = 1'b1;
    expect_val("coincident.MODE", m_mode);
    sb_check(MODE);
    SEL = 1'b0; IOWR = 1'b0;
    @(negedge clk);

    // Config write while HSYNC held high waits for next rise
    ga_write(8'h83, 3);
    check_all("cfg_hs_high");
    HSYNC = 1'b0;
    @(negedge clk); HSYNC = 1'b1;
    @(negedge clk);
    m_mode = 2'd3;
    expect_val("next_rise.MODE", m_mode);
    sb_check(MODE);
    HSYNC = 1'b0;
    expect_val("no_irq.pulses", 192'd0);
    sb_check(irq_cnt - irq0);

    // Long strobe: one event only, data change mid-strobe ignored
    @(negedge clk);
    SEL = 1'b1; IOWR = 1'b1; D = 8'hC7;
    repeat (3) @(negedge clk);
    D = 8'hC3;
    repeat (17) @(negedge clk);
    SEL = 1'b0; IOWR = 1'b0;
    @(negedge clk);
    m_ram = 6'h07;
    check_all("long_strobe");

    // Plus palette writes
    plus_write(6'h06, 8'hA5);
    plus_write(6'h07, 8'h0C);
    m_plus[3] = 12'hAC5;
    check_all("plus_ink3");
    plus_write(6'h21, 8'h03);
    m_pborder = 12'h030;
    check_all("plus_border");
    plus_write(6'h30, 8'hFF);
    check_all("plus_ignored");

    // Simultaneous GA colour write and Plus write to pen 2
    ga_write(8'h02, 2);
    @(negedge clk);
    SEL = 1'b1; IOWR = 1'b1; D = 8'h5A;
    PLUS_WR = 1'b1; PLUS_ADDR = 6'h04; PLUS_DATA = 8'h9F;
    repeat (2) @(negedge clk);
    SEL = 1'b0; IOWR = 1'b0; PLUS_WR = 1'b0;
    @(negedge clk);
    m_inkr[2] = 5'h1A;
    m_plus[2] = 12'h90F;
    check_all("simul");

    // Reset mid-strobe clears immediately; held strobe is a new event after release
    @(negedge clk);
    SEL = 1'b1; IOWR = 1'b1; D = 8'hC5;
    @(negedge clk);
    RESET_N = 1'b0;
    #1;
    m_inkr = '0; m_border = '0; m_plus = '0; m_pborder = '0;
    m_mode = '0; m_romlo = 1'b1; m_romhi = 1'b1; m_ram = '0;
    check_all("reset_mid");
    D = 8'hC9;
    @(negedge clk);
    RESET_N = 1'b1;
    @(negedge clk);
    m_ram = 6'h09;
    expect_val("post_reset_strobe.RAM_CFG", m_ram);
    sb_check(RAM_CFG);
    SEL = 1'b0; IOWR = 1'b0;
    @(negedge clk);

    expect_val("scoreboard_drained", 192'd0);
    sb_check(192'(sb_exp.size() - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
